// File: rtl/pipelined_wide_adder.sv
// Carry-segmented pipelined adder: one SW-bit slice is resolved per stage, and the
// carry is registered between slices. The pipe is fully pipelined with backpressure.
module pipelined_wide_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int SW = WIDTH / STAGES;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Producers never withdraw valid, and ready may depend combinationally on the other side's ready.
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] carry;
    logic [WIDTH-1:0]  a_r     [STAGES];
    logic [WIDTH-1:0]  b_r     [STAGES];
    logic [WIDTH-1:0]  res_r   [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_carry;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_res [STAGES];
    logic [SW:0]       slice   [STAGES];
    logic [WIDTH-1:0]  nxt_res [STAGES];

    // A stage may load when it or any stage after it is empty, or when the output drains.
    always_comb begin : adv_chain
        logic room;
        adv  = '0;
        room = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            room = out_ready;
            for (int j = k; j < STAGES; j++) begin
                room = room | ~valid[j];
            end
            adv[k] = room;
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_carry[0] = cin;
        src_a[0]     = a;
        src_b[0]     = b;
        src_res[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid[k-1];
            src_carry[k] = carry[k-1];
            src_a[k]     = a_r[k-1];
            src_b[k]     = b_r[k-1];
            src_res[k]   = res_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
                     + {{SW{1'b0}}, src_carry[k]};
            nxt_res[k] = src_res[k];
            nxt_res[k][k*SW +: SW] = slice[k][SW-1:0];
        end
    end

    // Data only moves with a valid token, so bubbles never disturb held results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            carry <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        a_r[k]   <= src_a[k];
                        b_r[k]   <= src_b[k];
                        carry[k] <= slice[k][SW];
                        res_r[k] <= nxt_res[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid[STAGES-1];
    assign sum       = res_r[STAGES-1];
    assign cout      = carry[STAGES-1];

endmodule
